debug_cmd_rx: RTL and testbench

- Receive-side counterpart of the debug print path: parses framed commands arriving on the UART RX byte stream.
- Delivers a destination/source address pair to the task manager in the same frame format the debug port prints: '$', dest[15:8], dest[7:0], src[15:8], src[7:0], '$'.
- Sits between the UART RX byte interface and the control logic.
- Enforces inter-byte timeouts and counts malformed frames.

---
 rtl/debug_cmd_rx.sv | 145 ++++++++++++++
 tb/tb_debug_cmd_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_cmd_rx.sv
// debug_cmd_rx -- parses '$'-framed address commands from the UART RX byte
// stream and hands the decoded destination/source pair to the task manager.
//
// Frame: '$', dest[15:8], dest[7:0], src[15:8], src[7:0], [chk], '$'
//   The optional checksum byte (xor of the four payload bytes) is present only
//   when DEBUG_CMD_CHECKSUM_EN is defined; otherwise the CHK state is not built.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_rdata, i_rready   show-ahead RX byte and its availability
//   o_rreq              consume the byte on i_rdata at this edge
//   o_destAddr/o_srcAddr  last published addresses
//   o_cmd_valid, i_cmd_ready  command handshake (held until accepted)
//   o_err_count         saturating count of malformed / timed-out frames
//   o_busy              a frame is in progress or a command is held
module debug_cmd_rx #(
  parameter logic [7:0] SOF_BYTE       = 8'h24,
  parameter int         TIMEOUT_CYCLES = 5000000,
  parameter int         TO_W           = 23
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rdata,
  input  logic        i_rready,
  output logic        o_rreq,
  output logic [15:0] o_destAddr,
  output logic [15:0] o_srcAddr,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic [7:0]  o_err_count,
  output logic        o_busy
);

`ifdef DEBUG_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, PAYLOAD, CHK, TAIL, HOLD} state_t;
`else
  typedef enum logic [2:0] {IDLE, PAYLOAD, TAIL, HOLD} state_t;
`endif

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_n;
  logic [1:0]      idx, idx_n;
  logic [15:0]     sh_dest, sh_dest_n, sh_src, sh_src_n;
  logic [TO_W-1:0] to_cnt;
  logic            take, in_frame, to_hit, publish, err;

  // HOLD stops popping so the UART FIFO backs up behind an unaccepted command.
  assign o_rreq = i_rst && i_rready && (state != HOLD);
  assign take   = o_rreq;
  assign o_busy = (state != IDLE);

`ifdef DEBUG_CMD_CHECKSUM_EN
  assign in_frame = (state == PAYLOAD) || (state == CHK) || (state == TAIL);
`else
  assign in_frame = (state == PAYLOAD) || (state == TAIL);
`endif
  assign to_hit = in_frame && !take && (to_cnt == TO_LAST);

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    sh_dest_n = sh_dest;
    sh_src_n  = sh_src;
    publish   = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: if (take && i_rdata == SOF_BYTE) begin
        state_n = PAYLOAD;
        idx_n   = 2'd0;
      end
      PAYLOAD: if (take) begin
        // payload is binary: SOF_BYTE here is data, not a marker
        case (idx)
          2'd0:    sh_dest_n[15:8] = i_rdata;
          2'd1:    sh_dest_n[7:0]  = i_rdata;
          2'd2:    sh_src_n[15:8]  = i_rdata;
          default: sh_src_n[7:0]   = i_rdata;
        endcase
        idx_n = idx + 2'd1;
`ifdef DEBUG_CMD_CHECKSUM_EN
        if (idx == 2'd3) state_n = CHK;
`else
        if (idx == 2'd3) state_n = TAIL;
`endif
      end
`ifdef DEBUG_CMD_CHECKSUM_EN
      CHK: if (take) begin
        if (i_rdata == (sh_dest[15:8] ^ sh_dest[7:0] ^ sh_src[15:8] ^ sh_src[7:0]))
          state_n = TAIL;
        else begin
          err     = 1'b1;
          state_n = IDLE;
        end
      end
`endif
      TAIL: if (take) begin
        if (i_rdata == SOF_BYTE) begin
          publish = 1'b1;
          state_n = HOLD;
        end else begin
          err     = 1'b1;
          state_n = IDLE;
        end
      end
      HOLD: if (i_cmd_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // a consumed byte wins over the timeout (to_hit already excludes take)
    if (to_hit) begin
      err     = 1'b1;
      state_n = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      sh_dest     <= 16'h0;
      sh_src      <= 16'h0;
      to_cnt      <= '0;
      o_destAddr  <= 16'h0;
      o_srcAddr   <= 16'h0;
      o_cmd_valid <= 1'b0;
      o_err_count <= 8'h0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      sh_dest <= sh_dest_n;
      sh_src  <= sh_src_n;
      // idle-cycle counter only runs while a frame is open and nothing arrives
      to_cnt  <= (in_frame && !take && !to_hit) ? to_cnt + TO_W'(1) : '0;
      if (publish) begin
        o_destAddr  <= sh_dest;
        o_srcAddr   <= sh_src;
        o_cmd_valid <= 1'b1;
      end else if (state == HOLD && i_cmd_ready) begin
        o_cmd_valid <= 1'b0;
      end
      if (err && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_debug_cmd_rx.sv
`define CHK(t, o, e) chk(t, 32'(o), 32'(e))

module tb_debug_cmd_rx;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rdata = 8'h0;
  logic        i_rready = 1'b0;
  logic        o_rreq;
  logic [15:0] o_destAddr, o_srcAddr;
  logic        o_cmd_valid;
  logic        i_cmd_ready;
  logic [7:0]  o_err_count;
  logic        o_busy;

  int vectors = 0;
  int errs    = 0;
  int acc     = 0;
  int acc0;
  logic [7:0] q[$];

  debug_cmd_rx #(.SOF_BYTE(8'h24), .TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rdata(i_rdata), .i_rready(i_rready),
    .o_rreq(o_rreq), .o_destAddr(o_destAddr), .o_srcAddr(o_srcAddr),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_err_count(o_err_count), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_rreq && q.size() != 0) void'(q.pop_front());
    if (o_cmd_valid && i_cmd_ready) acc++;
  end
  always @(negedge i_clk) begin
    i_rready = (q.size() != 0);
    i_rdata  = (q.size() != 0) ? q[0] : 8'h00;
  end

  always @(negedge i_clk) begin
    if (i_rst === 1'b1 && o_cmd_valid === 1'b1) begin
      vectors++;
      if (o_rreq !== 1'b0) begin
        errs++;
        $error("FAIL hold_rreq observed=%b expected=0", o_rreq);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic push_frame(input logic [15:0] d, input logic [15:0] s);
    q.push_back(8'h24);
    q.push_back(d[15:8]); q.push_back(d[7:0]);
    q.push_back(s[15:8]); q.push_back(s[7:0]);
`ifdef DEBUG_CMD_CHECKSUM_EN
    q.push_back(d[15:8] ^ d[7:0] ^ s[15:8] ^ s[7:0]);
`endif
    q.push_back(8'h24);
  endtask

  task automatic push_bad();
    q.push_back(8'h24); q.push_back(8'h11); q.push_back(8'h22);
    q.push_back(8'h33); q.push_back(8'h44); q.push_back(8'h55);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!o_cmd_valid && n < 200) begin tick(1); n++; end
    `CHK(tag, o_cmd_valid, 1'b1);
  endtask

  task automatic drain(input string tag, input int left);
    int n = 0;
    while (q.size() > left && n < 5000) begin tick(1); n++; end
    `CHK(tag, q.size(), left);
  endtask

  initial begin
    i_rst = 1'b0; i_cmd_ready = 1'b0;
    #1;
    `CHK("rst_valid", o_cmd_valid, 1'b0);
    `CHK("rst_dest",  o_destAddr, 16'h0);
    `CHK("rst_src",   o_srcAddr, 16'h0);
    `CHK("rst_err",   o_err_count, 8'h0);
    `CHK("rst_busy",  o_busy, 1'b0);
    `CHK("rst_rreq",  o_rreq, 1'b0);
    tick(2);
    i_rst = 1'b1;

    i_cmd_ready = 1'b1;
    q.push_back(8'h0A);
    push_frame(16'h1234, 16'hABCD);
    wait_valid("t1_valid");
    `CHK("t1_dest", o_destAddr, 16'h1234);
    `CHK("t1_src",  o_srcAddr, 16'hABCD);
    `CHK("t1_err",  o_err_count, 8'h0);
    vectors++;
    if (o_destAddr !== 16'h1234 || o_srcAddr !== 16'hABCD) begin
      errs++;
      $error("FAIL t1_pair observed=%h/%h expected=1234/abcd", o_destAddr, o_srcAddr);
    end
    tick(1);
    `CHK("t1_pulse", o_cmd_valid, 1'b0);
    `CHK("t1_idle",  o_busy, 1'b0);

    i_cmd_ready = 1'b0;
    push_frame(16'h1234, 16'hABCD);
    push_frame(16'h5566, 16'h7788);
    wait_valid("t2_valid");
    for (int i = 0; i < 20; i++) begin
      tick(1);
      `CHK("t2_rreq",  o_rreq, 1'b0);
      `CHK("t2_hold",  o_cmd_valid, 1'b1);
      `CHK("t2_dest",  o_destAddr, 16'h1234);
      `CHK("t2_src",   o_srcAddr, 16'hABCD);
    end
    i_cmd_ready = 1'b1;
    tick(1);
    `CHK("t2_clr", o_cmd_valid, 1'b0);
    wait_valid("t2_valid2");
    `CHK("t2_dest2", o_destAddr, 16'h5566);
    `CHK("t2_src2",  o_srcAddr, 16'h7788);
    tick(1);

    push_frame(16'h2424, 16'h2424);
    wait_valid("t3_valid");
    `CHK("t3_dest", o_destAddr, 16'h2424);
    `CHK("t3_src",  o_srcAddr, 16'h2424);
    tick(1);

    acc0 = acc;
    push_bad();
    push_frame(16'h0102, 16'h0304);
    wait_valid("t4_valid");
    `CHK("t4_err",  o_err_count, 8'd1);
    `CHK("t4_dest", o_destAddr, 16'h0102);
    `CHK("t4_src",  o_srcAddr, 16'h0304);
    vectors++;
    if (o_err_count !== 8'd1) begin
      errs++;
      $error("FAIL t4_err_inline observed=%h expected=01", o_err_count);
    end
    tick(1);
    `CHK("t4_acc", acc - acc0, 1);

    q.push_back(8'h24); q.push_back(8'h11);
    drain("t5_drain", 0);
    tick(15);
    `CHK("t5_busy_pre", o_busy, 1'b1);
    `CHK("t5_err_pre",  o_err_count, 8'd1);
    tick(1);
    `CHK("t5_busy", o_busy, 1'b0);
    `CHK("t5_err",  o_err_count, 8'd2);
    `CHK("t5_dest", o_destAddr, 16'h0102);
    `CHK("t5_src",  o_srcAddr, 16'h0304);

`ifdef DEBUG_CMD_CHECKSUM_EN
    acc0 = acc;
    q.push_back(8'h24); q.push_back(8'h12); q.push_back(8'h34);
    q.push_back(8'hAB); q.push_back(8'hCD); q.push_back(8'h41);
    q.push_back(8'h24);
    drain("t6_drain", 0);
    `CHK("t6_err",  o_err_count, 8'd3);
    `CHK("t6_dest", o_destAddr, 16'h0102);
    tick(20);
    `CHK("t6_acc",  acc - acc0, 0);
    `CHK("t6_err2", o_err_count, 8'd4);
    `CHK("t6_busy", o_busy, 1'b0);
`endif

    q.push_back(8'h24); q.push_back(8'h12); q.push_back(8'h34);
    drain("t7_drain", 1);
    #1;
    `CHK("t7_busy_pre", o_busy, 1'b1);
    i_rst = 1'b0;
    #1;
    `CHK("t7_rreq",  o_rreq, 1'b0);
    `CHK("t7_busy",  o_busy, 1'b0);
    `CHK("t7_dest",  o_destAddr, 16'h0);
    `CHK("t7_src",   o_srcAddr, 16'h0);
    `CHK("t7_err",   o_err_count, 8'h0);
    `CHK("t7_valid", o_cmd_valid, 1'b0);
    q.delete();
    tick(2);
    i_rst = 1'b1;

    acc0 = acc;
    for (int i = 0; i < 300; i++) push_bad();
    drain("t8_drain", 0);
    tick(2);
    `CHK("t8_err", o_err_count, 8'hFF);
    `CHK("t8_acc", acc - acc0, 0);
    vectors++;
    if (o_err_count !== 8'hFF) begin
      errs++;
      $error("FAIL t8_sat observed=%h expected=ff", o_err_count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
